// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: frames SPI byte traffic into single-cycle register bus reads/writes.
// Define SPI_REG_CTRL_AUTOINC_EN to advance reg_addr after every burst byte.
module spi_reg_ctrl #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk27m,
   input  logic              rst,
   input  logic              cs_active,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy,
   output logic              err_ovr
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_WR    = 3'd2;
   localparam logic [2:0] S_FETCH = 3'd3;
   localparam logic [2:0] S_LOAD  = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   logic [2:0]        r_state, w_next;
   logic [ADDR_W-1:0] r_addr, w_addr_inc;
   logic [DATA_W-1:0] r_tx, r_wdata;
   logic              r_start, r_we, r_re, r_busy, r_ovr;
   logic              w_cmd, w_wr, w_dummy, w_ovr;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   assign w_addr_inc = r_addr + ADDR_W'(1);
`else
   assign w_addr_inc = r_addr;
`endif

   assign w_cmd   = r_state == S_CMD && rx_valid;
   assign w_wr    = r_state == S_WR && rx_valid;
   assign w_dummy = r_state == S_WAIT && rx_valid;
   assign w_ovr   = (r_state == S_FETCH || r_state == S_LOAD) && rx_valid;

   // Losing chip-select forces IDLE from any state; the current byte is still acted on.
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = S_CMD;
         S_CMD:   w_next = rx_valid ? (rx_data[DATA_W-1] ? S_FETCH : S_WR) : S_CMD;
         S_WR:    w_next = S_WR;
         S_FETCH: w_next = S_LOAD;
         S_LOAD:  w_next = S_WAIT;
         S_WAIT:  w_next = rx_valid ? S_FETCH : S_WAIT;
         default: w_next = S_IDLE;
      endcase
      if (!cs_active) w_next = S_IDLE;
   end

   always_ff @(posedge clk27m) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_tx    <= '0;
         r_wdata <= '0;
         r_start <= 1'b0;
         r_we    <= 1'b0;
         r_re    <= 1'b0;
         r_busy  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= w_next != S_IDLE;
         r_re    <= w_next == S_FETCH;
         r_we    <= w_wr;
         r_start <= r_state == S_LOAD;
         if (w_wr) r_wdata <= rx_data;
         if (r_state == S_LOAD) r_tx <= reg_rdata;
         if (w_cmd) r_addr <= rx_data[ADDR_W-1:0];
         else if (r_we || w_dummy) r_addr <= w_addr_inc;
         if (r_state == S_IDLE && cs_active) r_ovr <= 1'b0;
         else if (w_ovr) r_ovr <= 1'b1;
      end
   end

   assign tx_data   = r_tx;
   assign tx_start  = r_start;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign reg_we    = r_we;
   assign reg_re    = r_re;
   assign busy      = r_busy;
   assign err_ovr   = r_ovr;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed and randomized checks of spi_reg_ctrl against a transaction-level model.
// Honours SPI_REG_CTRL_AUTOINC_EN the same way the design does.
module tb_spi_reg_ctrl;
`ifdef SPI_REG_CTRL_AUTOINC_EN
   localparam logic [6:0] INC = 7'd1;
`else
   localparam logic [6:0] INC = 7'd0;
`endif

   logic       clk27m = 1'b0, rst = 1'b1, cs_active = 1'b0, rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00, reg_rdata = 8'h00;
   logic [7:0] tx_data, reg_wdata;
   logic [6:0] reg_addr;
   logic       tx_start, reg_we, reg_re, busy, err_ovr;
   int         checks = 0, errors = 0, t = 0;

   always #5 clk27m = ~clk27m;

   spi_reg_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
      .clk27m(clk27m), .rst(rst), .cs_active(cs_active), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy), .err_ovr(err_ovr)
   );

   typedef struct {int t; logic [7:0] a; logic [7:0] d;} ev_t;
   ev_t        wq[$], rq[$], sq[$];
   logic [7:0] mem [128];

   // transaction-level model: open/closed transaction, pending command, read timeline by cycle stamp
   bit         m_active, m_cmd, m_wr, m_inc, m_ovr, e_we, e_re, e_start, re_last;
   int         m_rdc;
   logic [6:0] m_addr = 7'd0, addr_last = 7'd0;
   logic [7:0] m_wdata = 8'h00, m_tx = 8'h00;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", n, t, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit c, input bit v, input logic [7:0] d, input logic [7:0] rd);
      if (r) begin
         m_active = 0; m_cmd = 0; m_wr = 0; m_inc = 0; m_ovr = 0;
         e_we = 0; e_re = 0; e_start = 0;
         m_addr = 7'd0; m_wdata = 8'h00; m_tx = 8'h00;
         return;
      end
      e_we = 0; e_re = 0; e_start = 0;
      if (m_inc) m_addr = m_addr + INC;
      m_inc = 0;
      if (!m_active) begin
         if (c) begin m_active = 1; m_cmd = 1; m_ovr = 0; end
      end else begin
         if (m_cmd) begin
            if (v) begin
               m_addr = d[6:0]; m_cmd = 0; m_wr = !d[7]; m_rdc = t; e_re = d[7] && c;
            end
         end else if (m_wr) begin
            if (v) begin e_we = 1; m_wdata = d; m_inc = 1; end
         end else if (t - m_rdc <= 2) begin
            if (v) m_ovr = 1;
            if (t - m_rdc == 2) begin e_start = 1; m_tx = rd; end
         end else if (v) begin
            m_addr = m_addr + INC; m_rdc = t; e_re = c;
         end
         if (!c) m_active = 0;
      end
   endtask

   task automatic cyc(input bit r, input bit c, input bit v, input logic [7:0] d);
      rst = r; cs_active = c; rx_valid = v; rx_data = d;
      reg_rdata = re_last ? mem[addr_last] : 8'($urandom);
      re_last = e_re; addr_last = m_addr;
      model_step(r, c, v, d, reg_rdata);
      @(posedge clk27m); #1;
      t++;
      chk("reg_we", 32'(reg_we), 32'(e_we));
      chk("reg_re", 32'(reg_re), 32'(e_re));
      chk("tx_start", 32'(tx_start), 32'(e_start));
      chk("tx_data", 32'(tx_data), 32'(m_tx));
      chk("reg_addr", 32'(reg_addr), 32'(m_addr));
      chk("reg_wdata", 32'(reg_wdata), 32'(m_wdata));
      chk("busy", 32'(busy), 32'(m_active));
      chk("err_ovr", 32'(err_ovr), 32'(m_ovr));
      if (reg_we) wq.push_back('{t, 8'(reg_addr), reg_wdata});
      if (reg_re) rq.push_back('{t, 8'(reg_addr), 8'h00});
      if (tx_start) sq.push_back('{t, 8'h00, tx_data});
   endtask

   task automatic clrq();
      wq.delete(); rq.delete(); sq.delete();
   endtask

   task automatic pad();
      while (wq.size() < 4) wq.push_back('{-1, 8'hEE, 8'hEE});
      while (rq.size() < 4) rq.push_back('{-1, 8'hEE, 8'hEE});
      while (sq.size() < 4) sq.push_back('{-1, 8'hEE, 8'hEE});
   endtask

   initial begin
      bit         r, c, v;
      logic [7:0] d;
      int         n, n2, tc;
      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      mem[3] = 8'h3C; mem[4] = 8'h3D;

      cyc(1, 0, 0, 8'h00); cyc(1, 1, 1, 8'h85);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_addr", 32'(reg_addr), 0);
      chk("rst_tx", 32'(tx_data), 0);
      chk("rst_ovr", 32'(err_ovr), 0);

      clrq();
      cyc(0, 1, 0, 8'h00); cyc(0, 1, 1, 8'h05);
      n = t; cyc(0, 1, 1, 8'hAA); cyc(0, 1, 0, 8'h00);
      n2 = t; cyc(0, 1, 1, 8'hBB); cyc(0, 1, 0, 8'h00); cyc(0, 0, 0, 8'h00); cyc(0, 0, 0, 8'h00);
      chk("wb_cnt", wq.size(), 2); chk("wb_nostart", sq.size(), 0); pad();
      chk("wb0_t", wq[0].t, n + 1); chk("wb0_a", 32'(wq[0].a), 32'h05); chk("wb0_d", 32'(wq[0].d), 32'hAA);
      chk("wb1_t", wq[1].t, n2 + 1); chk("wb1_a", 32'(wq[1].a), 32'(7'h05 + INC)); chk("wb1_d", 32'(wq[1].d), 32'hBB);

      clrq();
      cyc(0, 1, 0, 8'h00); tc = t; cyc(0, 1, 1, 8'h83);
      repeat (3) cyc(0, 1, 0, 8'h00);
      cyc(0, 1, 1, 8'h00);
      repeat (4) cyc(0, 1, 0, 8'h00);
      cyc(0, 0, 0, 8'h00);
      chk("rb_re_cnt", rq.size(), 2); chk("rb_st_cnt", sq.size(), 2); chk("rb_nowe", wq.size(), 0); pad();
      chk("rb0_re_t", rq[0].t, tc + 1); chk("rb0_re_a", 32'(rq[0].a), 32'h03);
      chk("rb0_st_t", sq[0].t, tc + 3); chk("rb0_st_d", 32'(sq[0].d), 32'h3C);
      chk("rb1_re_a", 32'(rq[1].a), 32'(7'h03 + INC));
      chk("rb1_st_d", 32'(sq[1].d), (INC != 0) ? 32'h3D : 32'h3C);

      clrq();
      cyc(0, 1, 0, 8'h00); cyc(0, 1, 1, 8'h7F); cyc(0, 1, 1, 8'h11); cyc(0, 1, 1, 8'h22);
      cyc(0, 1, 0, 8'h00); cyc(0, 0, 0, 8'h00); cyc(0, 0, 0, 8'h00);
      chk("wrap_cnt", wq.size(), 2); pad();
      chk("wrap0_a", 32'(wq[0].a), 32'h7F); chk("wrap1_a", 32'(wq[1].a), 32'(7'(7'h7F + INC)));

      clrq();
      cyc(0, 1, 0, 8'h00); tc = t; cyc(0, 1, 1, 8'h80); cyc(0, 1, 0, 8'h00);
      cyc(0, 1, 1, 8'h55); cyc(0, 1, 0, 8'h00);
      chk("ovr_set", 32'(err_ovr), 1);
      cyc(0, 1, 0, 8'h00); cyc(0, 0, 0, 8'h00);
      chk("ovr_sticky", 32'(err_ovr), 1);
      chk("ovr_re_cnt", rq.size(), 1); chk("ovr_st_cnt", sq.size(), 1); pad();
      chk("ovr_st_t", sq[0].t, tc + 3); chk("ovr_st_d", 32'(sq[0].d), 32'(mem[0]));
      cyc(0, 1, 0, 8'h00);
      chk("ovr_clr", 32'(err_ovr), 0);
      cyc(0, 0, 0, 8'h00);

      clrq();
      cyc(0, 1, 0, 8'h00); cyc(0, 1, 1, 8'h81); cyc(0, 0, 0, 8'h00);
      chk("abort_busy", 32'(busy), 0);
      repeat (3) cyc(0, 0, 0, 8'h00);
      chk("abort_nostart", sq.size(), 0);
      cyc(0, 1, 0, 8'h00); cyc(0, 1, 1, 8'h10); cyc(0, 1, 1, 8'h55); cyc(0, 1, 0, 8'h00); cyc(0, 0, 0, 8'h00);
      chk("abort_wr_cnt", wq.size(), 1); pad();
      chk("abort_wr_a", 32'(wq[0].a), 32'h10); chk("abort_wr_d", 32'(wq[0].d), 32'h55);

      clrq();
      cyc(0, 1, 0, 8'h00); cyc(0, 1, 1, 8'h20); cyc(1, 1, 1, 8'h77);
      chk("rstw_nowe", wq.size(), 0);
      chk("rstw_busy", 32'(busy), 0); chk("rstw_addr", 32'(reg_addr), 0);
      chk("rstw_wdata", 32'(reg_wdata), 0); chk("rstw_tx", 32'(tx_data), 0);
      cyc(0, 1, 0, 8'h00);
      chk("rstw_busy_up", 32'(busy), 1);
      cyc(0, 1, 1, 8'h21); cyc(0, 1, 1, 8'h99); cyc(0, 0, 0, 8'h00);
      chk("rstw_wr_cnt", wq.size(), 1); pad();
      chk("rstw_wr_a", 32'(wq[0].a), 32'h21); chk("rstw_wr_d", 32'(wq[0].d), 32'h99);

      c = 0;
      repeat (4000) begin
         r = $urandom_range(0, 299) == 0;
         if ($urandom_range(0, 39) == 0) c = !c;
         v = $urandom_range(0, 2) == 0;
         d = 8'($urandom);
         cyc(r, c, v, d);
      end
      cyc(0, 0, 0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
